// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32 OP/OP-IMM decode constants, types and decode helper
package riscv_pkg;

    localparam logic [6:0] ALU_I_OP   = 7'b0010011;
    localparam logic [6:0] ALU_R_OP   = 7'b0110011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } alu_f3_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1_idx;
        logic [4:0]  rs2_idx;
        alu_f3_e     f3;
        logic [11:0] imm;
        logic        is_r;
        logic        legal;
    } dec_instr_t;

    // Field extraction plus legality; shift-immediates constrain the funct7 slot.
    function automatic dec_instr_t decode(input logic [31:0] w);
        dec_instr_t d;
        logic [6:0] f7;
        f7        = w[31:25];
        d.rd      = w[11:7];
        d.rs1_idx = w[19:15];
        d.rs2_idx = w[24:20];
        d.f3      = alu_f3_e'(w[14:12]);
        d.imm     = w[31:20];
        d.is_r    = (w[6:0] == ALU_R_OP);
        d.legal   = 1'b0;
        if (w[6:0] == ALU_I_OP) begin
            case (d.f3)
                F3_SLL:  d.legal = (f7 == F7_BASE);
                F3_SR:   d.legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                default: d.legal = 1'b1;
            endcase
        end else if (d.is_r) begin
            d.legal = (f7 == F7_BASE) || (f7 == F7_ALT) || (f7 == F7_MULDIV);
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 32 x XLEN register file, two async reads, one sync write, x0 fixed at zero
module alu_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [4:0]      ra_a_i,
    input  logic [4:0]      ra_b_i,
    output logic [XLEN-1:0] rd_a_o,
    output logic [XLEN-1:0] rd_b_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] mem_q [32];

    // Clear everything on reset; otherwise write any register except x0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign rd_a_o = (ra_a_i == 5'd0) ? '0 : mem_q[ra_a_i];
    assign rd_b_o = (ra_b_i == 5'd0) ? '0 : mem_q[ra_b_i];

endmodule

// File: rtl/alu_issue_wb.sv
// rtl/alu_issue_wb.sv - issue/writeback stage around the RV32IM ALU; ALU_BYPASS_EN enables aluOut forwarding
module alu_issue_wb
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [31:0]         instr,
    output logic                opcodeValid,
    output logic [6:0]          opcode,
    output logic [3:0]          f3,
    output logic [11:0]         imm,
    output logic [XLEN-1:0]     rs1,
    output logic [XLEN-1:0]     rs2,
    input  logic [XLEN-1:0]     aluOut,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                illegal_instr,
    output logic [RETIRE_W-1:0] retire_count
);

    dec_instr_t          dec;
    logic                pend_q;
    logic [4:0]          pend_rd_q;
    logic                ill_q;
    logic [RETIRE_W-1:0] retire_q;
    logic [XLEN-1:0]     rf_a;
    logic [XLEN-1:0]     rf_b;
    logic [XLEN-1:0]     op_a;
    logic [XLEN-1:0]     op_b;
    logic                pend_live;
    logic                match_a;
    logic                match_b;
    logic                accept;
    logic                issue;

    assign dec       = decode(instr);
    // A pending write to x0 never creates a dependency.
    assign pend_live = pend_q && (pend_rd_q != 5'd0);
    assign match_a   = pend_live && (dec.rs1_idx == pend_rd_q);
    assign match_b   = pend_live && dec.is_r && (dec.rs2_idx == pend_rd_q);

`ifdef ALU_BYPASS_EN
    assign instr_ready = !rst;
    assign op_a        = match_a ? aluOut : rf_a;
    assign op_b        = match_b ? aluOut : rf_b;
`else
    logic hazard;
    // The RF still holds the old value during the writeback cycle, so hold off one cycle.
    assign hazard      = dec.legal && (match_a || match_b);
    assign instr_ready = !rst && !hazard;
    assign op_a        = rf_a;
    assign op_b        = rf_b;
`endif

    assign accept = instr_valid && instr_ready;
    assign issue  = accept && dec.legal;

    alu_regfile #(.XLEN(XLEN)) u_rf (
        .clk_i  (clk),
        .rst_i  (rst),
        .ra_a_i (dec.rs1_idx),
        .ra_b_i (dec.rs2_idx),
        .rd_a_o (rf_a),
        .rd_b_o (rf_b),
        .we_i   (wb_valid),
        .wa_i   (pend_rd_q),
        .wd_i   (aluOut)
    );

    // Everything toward the ALU is zero unless a legal instruction issues.
    assign opcodeValid = issue;
    assign opcode      = issue ? instr[6:0] : 7'd0;
    assign f3          = issue ? {1'b0, dec.f3} : 4'd0;
    assign imm         = issue ? dec.imm : 12'd0;
    assign rs1         = issue ? op_a : '0;
    assign rs2         = (issue && dec.is_r) ? op_b : '0;

    // Reset in the writeback slot squashes the write, the pulse and the count.
    assign wb_valid      = pend_q && !rst;
    assign wb_rd         = wb_valid ? pend_rd_q : 5'd0;
    assign wb_data       = rst ? '0 : aluOut;
    assign illegal_instr = ill_q && !rst;
    assign retire_count  = retire_q;

    // Track the in-flight instruction across the ALU's one-cycle latency and count retirements.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= 1'b0;
            pend_rd_q <= 5'd0;
            ill_q     <= 1'b0;
            retire_q  <= '0;
        end else begin
            pend_q    <= issue;
            pend_rd_q <= issue ? dec.rd : 5'd0;
            ill_q     <= accept && !dec.legal;
            if (wb_valid) begin
                retire_q <= retire_q + RETIRE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb/tb_alu_issue_wb.sv - scoreboard bench for alu_issue_wb with a small ALU model
module tb_alu_issue_wb;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        opcodeValid;
    logic [6:0]  opcode;
    logic [3:0]  f3;
    logic [11:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] aluOut;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal_instr;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_issue_wb #(.XLEN(32), .RETIRE_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .opcodeValid   (opcodeValid),
        .opcode        (opcode),
        .f3            (f3),
        .imm           (imm),
        .rs1           (rs1),
        .rs2           (rs2),
        .aluOut        (aluOut),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .illegal_instr (illegal_instr),
        .retire_count  (retire_count)
    );

    // Minimal registered ALU: ADD/ADDI and MUL are all this bench issues.
    always @(posedge clk) begin
        if (rst || !opcodeValid) begin
            aluOut <= 32'd0;
        end else if (opcode == ALU_I_OP && f3 == 4'd0) begin
            aluOut <= rs1 + {{20{imm[11]}}, imm};
        end else if (opcode == ALU_R_OP && f3 == 4'd0 && imm[11:5] == F7_BASE) begin
            aluOut <= rs1 + rs2;
        end else if (opcode == ALU_R_OP && f3 == 4'd0 && imm[11:5] == F7_MULDIV) begin
            aluOut <= rs1 * rs2;
        end else begin
            aluOut <= 32'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every writeback or illegal pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (wb_valid || illegal_instr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_slot wb_valid=%0b wb_rd=%0d wb_data=%h illegal=%0b expected=none",
                         wb_valid, wb_rd, wb_data, illegal_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_illegal", 32'(illegal_instr), 32'(e.ill));
                chk("sb_wb_valid", 32'(wb_valid), 32'(!e.ill));
                if (!e.ill) begin
                    chk("sb_wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("sb_wb_data", wb_data, e.data);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] w, input logic ill, input logic [4:0] rd,
                         input logic [31:0] data, input logic push, input logic chk_ops,
                         input logic [31:0] exp_a, input logic [31:0] exp_b, output int stalls);
        exp_t e;
        stalls = 0;
        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        #1;
        while (!instr_ready && stalls < 4) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout instr=%h instr_ready=0 expected=1", w);
        end else begin
            chk("issue_opvalid", 32'(opcodeValid), 32'(!ill));
            if (chk_ops) begin
                chk("issue_rs1", rs1, exp_a);
                chk("issue_rs2", rs2, exp_b);
            end
            if (push) begin
                e.ill  = ill;
                e.rd   = rd;
                e.data = data;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 32'd0;
    endtask

    initial begin
        int s;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_opvalid", 32'(opcodeValid), 32'd0);
        chk("rst_illegal", 32'(illegal_instr), 32'd0);
        chk("rst_retire", retire_count, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(instr_ready), 32'd1);
        instr       = 32'h0010_8133;
        instr_valid = 1'b1;
        #1;
        chk("rf_clear_rs1", rs1, 32'd0);
        chk("rf_clear_rs2", rs2, 32'd0);
        instr_valid = 1'b0;
        instr       = 32'd0;

        // ADDI x1,x0,5 ; ADD x2,x1,x1 ; MUL x3,x2,x1
        issue(32'h0050_0093, 1'b0, 5'd1, 32'd5, 1'b1, 1'b1, 32'd0, 32'd0, s);
        chk("addi_no_stall", 32'(s), 32'd0);
        issue(32'h0010_8133, 1'b0, 5'd2, 32'd10, 1'b1, 1'b1, 32'd5, 32'd5, s);
`ifdef ALU_BYPASS_EN
        chk("add_stalls", 32'(s), 32'd0);
`else
        chk("add_stalls", 32'(s), 32'd1);
`endif
        issue(32'h0211_01B3, 1'b0, 5'd3, 32'd50, 1'b1, 1'b1, 32'd10, 32'd5, s);
`ifdef ALU_BYPASS_EN
        chk("mul_stalls", 32'(s), 32'd0);
`else
        chk("mul_stalls", 32'(s), 32'd1);
`endif
        @(posedge clk);
        #1;
        chk("retire_after_mul", retire_count, 32'd3);

        // LOAD: consumed as illegal
        issue(32'h0000_0003, 1'b1, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, s);
        @(posedge clk);
        #1;
        chk("retire_after_load", retire_count, 32'd3);

        // ADDI x0,x0,7 retires but leaves x0 at zero
        issue(32'h0070_0013, 1'b0, 5'd0, 32'd7, 1'b1, 1'b1, 32'd0, 32'd0, s);
        @(posedge clk);
        #1;
        chk("retire_after_x0", retire_count, 32'd4);
        issue(32'h0000_0233, 1'b0, 5'd4, 32'd0, 1'b1, 1'b1, 32'd0, 32'd0, s);
        @(posedge clk);
        #1;
        chk("retire_after_x4", retire_count, 32'd5);

        // Reset in the writeback slot squashes ADDI x1,x0,5
        issue(32'h0050_0093, 1'b0, 5'd1, 32'd5, 1'b0, 1'b1, 32'd0, 32'd0, s);
        rst = 1'b1;
        #1;
        chk("rst_squash_wb", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_squash_retire", retire_count, 32'd0);
        @(negedge clk);
        instr       = 32'h0010_8133;
        instr_valid = 1'b1;
        #1;
        chk("rst_squash_x1", rs1, 32'd0);
        instr_valid = 1'b0;
        instr       = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
